three_input_nor_gate_checker: RTL

// - Synthesizable response checker for the three-input NOR gate; the receiving end of its a/b/c -> d/e interface.
// - Watches the gate inputs a,b,c and outputs d,e. Both d and e must equal ~(a|b|c):
//   d is the direct NOR, e is the NOR built from 2-input gates.
// - Waits for the inputs to settle, compares each vector, and tracks coverage of all 8 vectors.
// - Counts errors, captures the first failure, and flags done/pass.
// - Replaces the manual waveform inspection at the end of an exhaustive stimulus sweep.

---
 rtl/three_input_nor_gate_checker_pkg.sv | 17 +
 rtl/three_input_nor_gate_checker_settle_timer.sv | 52 +++++
 rtl/three_input_nor_gate_checker.sv | 112 +++++++++++
 3 files changed

// File: rtl/three_input_nor_gate_checker_pkg.sv
// Shared types and golden model for the three-input NOR gate response checker.
package three_input_gate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int         NUM_VECTORS = 8;
   localparam logic [7:0] COV_FULL    = 8'hFF;

   function automatic logic nor3_exp(input logic a, input logic b, input logic c);
      return ~(a | b | c);
   endfunction

endpackage

// File: rtl/three_input_nor_gate_checker_settle_timer.sv
// Raises a one-cycle fire strobe once vec has held still for SETTLE_CYCLES clock
// edges, counting the edge that captured the change (or the clr edge) as the first.
module input_settle_timer #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [2:0] vec,
   output logic       fire
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   // fire is registered downstream, so it is raised one count early.
   localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

   logic [2:0]       abc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             armed_q;
   logic             restart;

   assign restart = clr | (vec != abc_q);

   always_comb begin
      fire = 1'b0;
      if (SETTLE_CYCLES == 1) begin
         fire = restart;
      end else begin
         fire = armed_q & ~restart & (cnt_q == FIRE_AT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abc_q   <= 3'b000;
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         abc_q <= vec;
         if (restart) begin
            cnt_q   <= '0;
            armed_q <= (SETTLE_CYCLES == 1) ? 1'b0 : 1'b1;
         end else if (armed_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (fire) begin
               armed_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/three_input_nor_gate_checker.sv
// Response checker for a three-input NOR gate: compares d and e against ~(a|b|c)
// once per settled input vector, tracks coverage of all 8 vectors and logs errors.
module three_input_nor_gate_checker
   import three_input_gate_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             e,
   output logic             check_pulse,
   output logic             mismatch,
   output logic [7:0]       cov_map,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_vld,
   output logic [2:0]       first_err_vec,
   output logic [1:0]       first_err_de,
   output logic             done,
   output logic             pass,
   output logic [1:0]       state_dbg
);

   state_e     state_q, state_d;
   logic [2:0] vec;
   logic       start_run;
   logic       fire;
   logic       do_check;
   logic       exp_val;
   logic       bad;

   assign vec       = {a, b, c};
   assign start_run = start & (state_q != ST_RUN);
   assign exp_val   = nor3_exp(a, b, c);
   assign bad       = (d != exp_val) | (e != exp_val);
   // No compares once coverage is complete; the FSM leaves RUN on the next edge.
   assign do_check  = fire & (state_q == ST_RUN) & (cov_map != COV_FULL);

   input_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (start_run),
      .vec  (vec),
      .fire (fire)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cov_map == COV_FULL) state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         check_pulse   <= 1'b0;
         mismatch      <= 1'b0;
         cov_map       <= '0;
         err_count     <= '0;
         first_err_vld <= 1'b0;
         first_err_vec <= 3'b000;
         first_err_de  <= 2'b00;
      end else if (start_run) begin
         check_pulse   <= 1'b0;
         mismatch      <= 1'b0;
         cov_map       <= '0;
         err_count     <= '0;
         first_err_vld <= 1'b0;
         first_err_vec <= 3'b000;
         first_err_de  <= 2'b00;
      end else begin
         check_pulse <= do_check;
         mismatch    <= do_check & bad;
         if (do_check) begin
            cov_map[vec] <= 1'b1;
            if (bad) begin
               if (err_count != '1) begin
                  err_count <= err_count + 1'b1;
               end
               if (!first_err_vld) begin
                  first_err_vld <= 1'b1;
                  first_err_vec <= vec;
                  first_err_de  <= {d, e};
               end
            end
         end
      end
   end

   assign done      = (state_q == ST_DONE);
   assign pass      = done & (err_count == '0);
   assign state_dbg = state_q;

endmodule
